// File: rtl/mv_pkg.sv
// Shared sizes, FSM state type and default coefficient pattern for the
// matrix-vector multiply sequencer.
package mv_pkg;

  localparam int N     = 6;
  localparam int DW    = 8;
  localparam int ACC_W = 11;
  localparam int NCOEF = N * N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Coefficient loaded into M[i][j] on reset.
  function automatic logic [DW-1:0] def_coef(input int i, input int j);
    return DW'(16 * i + j + 1);
  endfunction

endpackage

// File: rtl/mv_mac.sv
// Gated add accumulator shared by all result columns.
module mv_mac
  import mv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             sel_bit,
  input  logic [DW-1:0]    coef,
  output logic [ACC_W-1:0] acc
);

  // Clear has priority; otherwise add the coefficient when its row is selected.
  always_ff @(posedge clk) begin
    if (rst)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en && sel_bit)
      acc <= acc + ACC_W'(coef);
  end

endmodule

// File: rtl/mv_mult_sched.sv
// Matrix-vector multiply sequencer: owns the coefficient matrix and walks one
// accumulator over every column, emitting each result on a valid/ready stream.
//
// state | meaning
// IDLE  | ready for start; matrix writes accepted
// MAC   | accumulating rows 0..N-1 of column j, one row per cycle
// EMIT  | result of column j presented, waiting for res_ready
// DONE  | one-cycle done pulse after the last column left
module mv_mult_sched
  import mv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [5:0]       cfg_addr,
  input  logic [DW-1:0]    cfg_data,
  input  logic             start,
  input  logic [N-1:0]     vec,
  output logic             ready,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2:0]       res_idx,
  output logic [ACC_W-1:0] res_data,
  output logic             done
);

  localparam logic [2:0] LAST = 3'(N - 1);

  state_t            state, state_n;
  logic [2:0]        i_q, j_q;
  logic [N-1:0]      vec_q;
  logic [DW-1:0]     mem [NCOEF];
  logic [5:0]        rd_idx;
  logic              accept, col_next, mac_clr, mac_en;
  logic [ACC_W-1:0]  acc;

  assign rd_idx   = 6'(i_q) * 6'(N) + 6'(j_q);
  assign res_idx  = j_q;
  assign res_data = acc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Next state and per-state control/outputs.
  always_comb begin
    state_n   = state;
    ready     = 1'b0;
    busy      = 1'b0;
    res_valid = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    col_next  = 1'b0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept  = 1'b1;
          mac_clr = 1'b1;
          state_n = MAC;
        end
      end
      MAC: begin
        busy   = 1'b1;
        mac_en = 1'b1;
        if (i_q == LAST)
          state_n = EMIT;
      end
      EMIT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          if (j_q == LAST) begin
            state_n = DONE;
          end else begin
            col_next = 1'b1;
            mac_clr  = 1'b1;
            state_n  = MAC;
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Row/column counters and the vector captured at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q   <= '0;
      j_q   <= '0;
      vec_q <= '0;
    end else begin
      if (accept) begin
        vec_q <= vec;
        i_q   <= '0;
        j_q   <= '0;
      end
      if (mac_en)
        i_q <= (i_q == LAST) ? 3'd0 : i_q + 3'd1;
      if (col_next)
        j_q <= j_q + 3'd1;
    end
  end

  // Coefficient file; writable only while idle so a compute sees a frozen matrix.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          mem[i*N+j] <= def_coef(i, j);
    end else if (cfg_we && state == IDLE && cfg_addr < 6'(NCOEF)) begin
      mem[cfg_addr] <= cfg_data;
    end
  end

  mv_mac u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (mac_clr),
    .en      (mac_en),
    .sel_bit (vec_q[i_q]),
    .coef    (mem[rd_idx]),
    .acc     (acc)
  );

endmodule
